// File: rtl/decoder_pkg.sv
// Shared definitions for the sequenced 3-to-8 decoder: state encoding,
// field widths and the one-hot helper used by the decode register.
package decoder_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  // One-hot of a code, bit k set for code k.
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] one;
    one = {{(ONEHOT_W-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage

// File: rtl/dec_hold_cnt.sv
// Loadable down-counter with zero flag. One instance times both the HOLD
// and the GAP phase; the counter parks at zero when not reloaded.
module dec_hold_cnt
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder3x8_seq.sv
// Sequenced 3-to-8 decoder: accepts a code, drives its one-hot for
// HOLD_CYCLES cycles, then forces GAP_CYCLES idle cycles before the next.
//
//   state | meaning
//   IDLE  | o_de low, ready for a new code when en is high
//   HOLD  | one-hot of the accepted code driven, counter running
//   GAP   | o_de low, enforced spacing before returning to IDLE
module decoder3x8_seq
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                i_valid,
  input  logic [CODE_W-1:0]   i_de,
  output logic                o_ready,
  output logic [ONEHOT_W-1:0] o_de,
  output logic                o_busy,
  output logic                o_done,
  output logic [CNT_W-1:0]    o_count
);

  // Counter reload values: the counter reads N-1 on the first cycle of an
  // N-cycle phase so the zero flag marks the last cycle.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_e              state_q, state_d;
  logic [ONEHOT_W-1:0] de_q, de_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             accept;

  dec_hold_cnt u_hold_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign o_ready = (state_q == IDLE) && en;
  assign accept  = i_valid && o_ready;

  // State, decode output and accept count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      de_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      de_q    <= de_d;
      count_q <= count_d;
    end
  end

  // Next-state, counter control and decode; i_de is only looked at on accept
  // so an undriven code outside a handshake cannot reach any register.
  always_comb begin
    state_d      = state_q;
    de_d         = de_q;
    count_d      = count_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      IDLE: begin
        de_d = '0;
        if (accept) begin
          state_d      = HOLD;
          de_d         = onehot(i_de);
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LOAD;
          if (count_q != '1) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          de_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d      = GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        de_d = '0;
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        de_d    = '0;
      end
    endcase
  end

  assign o_de    = de_q;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == HOLD) && cnt_zero;
  assign o_count = count_q;

endmodule
